// File: rtl/text_buffer_ctrl.sv
// Character buffer controller for the text display: cursor-driven writes, newline/backspace,
// wrap, scroll and full clear, plus a registered display lookup with a blinking cursor overlay.
module text_buffer_ctrl #(
  parameter int unsigned ROW_NUMBER     = 16,
  parameter int unsigned COL_NUMBER     = 32,
  parameter int unsigned ROW_BIT_LEN    = 4,
  parameter int unsigned COL_BIT_LEN    = 5,
  parameter int unsigned CHAR_ID_LENGTH = 8,
  parameter logic [CHAR_ID_LENGTH-1:0] BLANK_ID  = CHAR_ID_LENGTH'(32),
  parameter logic [CHAR_ID_LENGTH-1:0] CURSOR_ID = CHAR_ID_LENGTH'(128),
  parameter int unsigned BLINK_CYCLES   = 12_500_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [7:0]                in_char,
  input  logic                      clear,
  input  logic [ROW_BIT_LEN-1:0]    char_row,
  input  logic [COL_BIT_LEN-1:0]    char_col,
  output logic [CHAR_ID_LENGTH-1:0] character_id,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col,
  output logic                      busy
);

  localparam int unsigned ADDR_W  = ROW_BIT_LEN + COL_BIT_LEN;
  localparam int unsigned DEPTH   = ROW_NUMBER * COL_NUMBER;
  localparam int unsigned BLINK_W = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;

  localparam logic [ADDR_W-1:0]      LAST_IDX     = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]      SCROLL_SPLIT = ADDR_W'(DEPTH - COL_NUMBER);
  localparam logic [ADDR_W-1:0]      ROW_STRIDE   = ADDR_W'(COL_NUMBER);
  localparam logic [ROW_BIT_LEN-1:0] LAST_ROW     = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0] LAST_COL     = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [BLINK_W-1:0]     BLINK_LAST   = BLINK_W'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLEAR  = 2'd1,
    SCROLL = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        idx_q, idx_d;
  logic                     pend_q, pend_d;
  logic [ROW_BIT_LEN-1:0]   row_q, row_d;
  logic [COL_BIT_LEN-1:0]   col_q, col_d;
  logic [BLINK_W-1:0]       blink_cnt_q;
  logic                     blink_on_q;
  logic [CHAR_ID_LENGTH-1:0] char_id_q;

  logic [CHAR_ID_LENGTH-1:0] mem [DEPTH];

  logic                      we;
  logic [ADDR_W-1:0]         waddr;
  logic [CHAR_ID_LENGTH-1:0] wdata;
  logic                      accept;
  logic                      line_feed;

  assign busy     = (state_q != IDLE);
  assign in_ready = (state_q == IDLE) && !clear && !pend_q;
  assign accept   = in_valid && in_ready;

  assign character_id = char_id_q;
  assign cursor_row   = row_q;
  assign cursor_col   = col_q;

  // Next-state, cursor and write-port control
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    row_d     = row_q;
    col_d     = col_q;
    we        = 1'b0;
    waddr     = idx_q;
    wdata     = BLANK_ID;
    line_feed = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (clear || pend_q) begin
          state_d = CLEAR;
          idx_d   = '0;
          pend_d  = 1'b0;
        end else if (accept) begin
          if (in_char >= 8'h20 && in_char <= 8'h7E) begin
            we    = 1'b1;
            waddr = {row_q, col_q};
            wdata = CHAR_ID_LENGTH'(in_char);
            if (col_q == LAST_COL) begin
              line_feed = 1'b1;
            end else begin
              col_d = col_q + 1'b1;
            end
          end else if (in_char == 8'h0A || in_char == 8'h0D) begin
            line_feed = 1'b1;
          end else if (in_char == 8'h08) begin
            if (col_q != '0) begin
              col_d = col_q - 1'b1;
              we    = 1'b1;
              waddr = {row_q, col_q - 1'b1};
            end else if (row_q != '0) begin
              row_d = row_q - 1'b1;
              col_d = LAST_COL;
              we    = 1'b1;
              waddr = {row_q - 1'b1, LAST_COL};
            end
          end
          // Moving past the bottom row keeps the cursor on it and scrolls the page up
          if (line_feed) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              state_d = SCROLL;
              idx_d   = '0;
            end else begin
              row_d = row_q + 1'b1;
            end
          end
        end
      end

      CLEAR: begin
        we    = 1'b1;
        waddr = idx_q;
        wdata = BLANK_ID;
        if (idx_q == LAST_IDX) begin
          state_d = IDLE;
          row_d   = '0;
          col_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      SCROLL: begin
        we    = 1'b1;
        waddr = idx_q;
        wdata = (idx_q < SCROLL_SPLIT) ? mem[idx_q + ROW_STRIDE] : BLANK_ID;
        if (clear) begin
          pend_d = 1'b1;
        end
        if (idx_q == LAST_IDX) begin
          idx_d = '0;
          if (pend_q || clear) begin
            state_d = CLEAR;
            pend_d  = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end

      default: begin
        state_d = CLEAR;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CLEAR;
      idx_q   <= '0;
      pend_q  <= 1'b0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Storage has no reset; a reset edge suppresses the write
  always_ff @(posedge clk) begin
    if (we && !reset) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      blink_cnt_q <= '0;
      blink_on_q  <= 1'b1;
    end else if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_q <= '0;
      blink_on_q  <= !blink_on_q;
    end else begin
      blink_cnt_q <= blink_cnt_q + 1'b1;
    end
  end

  // Display lookup reads the pre-edge contents, so same-edge writes show one cycle later
  always_ff @(posedge clk) begin
    if (reset) begin
      char_id_q <= BLANK_ID;
    end else if (blink_on_q && char_row == row_q && char_col == col_q) begin
      char_id_q <= CURSOR_ID;
    end else begin
      char_id_q <= mem[{char_row, char_col}];
    end
  end

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Self-checking bench for text_buffer_ctrl: random character streams against a
// whole-page reference model with blink-phase-aware lookup expectations.
module tb_text_buffer_ctrl;

  localparam int BLINK = 8;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_char;
  logic       clear;
  logic [3:0] char_row;
  logic [4:0] char_col;
  logic [7:0] character_id;
  logic [3:0] cursor_row;
  logic [4:0] cursor_col;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  int model_mem [512];
  int m_row, m_col;
  int tb_cyc = 0;

  text_buffer_ctrl #(.BLINK_CYCLES(BLINK)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_char(in_char), .clear(clear), .char_row(char_row), .char_col(char_col),
    .character_id(character_id), .cursor_row(cursor_row), .cursor_col(cursor_col),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Edges elapsed since the last reset edge
  always @(posedge clk) begin
    if (reset) tb_cyc <= 0;
    else       tb_cyc <= tb_cyc + 1;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Blink phase used by a lookup whose edge has just passed
  function automatic bit blink_now();
    return (((tb_cyc - 1) / BLINK) % 2) == 0;
  endfunction

  function automatic int expect_cell(int r, int c);
    if (blink_now() && r == m_row && c == m_col) return 128;
    return model_mem[r*32 + c];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 512; i++) model_mem[i] = 32;
    m_row = 0;
    m_col = 0;
  endtask

  task automatic model_apply(input logic [7:0] ch, output bit scrolled);
    scrolled = 1'b0;
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      model_mem[m_row*32 + m_col] = int'(ch);
      m_col++;
      if (m_col == 32) begin
        m_col = 0;
        m_row++;
      end
    end else if (ch == 8'h0A || ch == 8'h0D) begin
      m_col = 0;
      m_row++;
    end else if (ch == 8'h08) begin
      if (m_col > 0) begin
        m_col--;
        model_mem[m_row*32 + m_col] = 32;
      end else if (m_row > 0) begin
        m_row--;
        m_col = 31;
        model_mem[m_row*32 + m_col] = 32;
      end
    end
    if (m_row == 16) begin
      m_row = 15;
      scrolled = 1'b1;
      for (int i = 0; i < 480; i++) model_mem[i] = model_mem[i+32];
      for (int i = 480; i < 512; i++) model_mem[i] = 32;
    end
  endtask

  // Drive one character for one edge (caller ensures in_ready) and update the model
  task automatic send_char(input logic [7:0] ch, output bit scrolled);
    in_valid = 1'b1;
    in_char  = ch;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    model_apply(ch, scrolled);
  endtask

  task automatic lookup(input int r, input int c, output int got, output int exp);
    char_row = 4'(r);
    char_col = 5'(c);
    @(posedge clk);
    @(negedge clk);
    got = int'(character_id);
    exp = expect_cell(r, c);
  endtask

  // Count consecutive busy samples starting with the current one, bounded
  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 3000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    int n;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags: busy=%0b in_ready=%0b required busy=1 in_ready=0", busy, in_ready);
    end
    checks++;
    if (cursor_row !== 4'd0 || cursor_col !== 5'd0 || character_id !== 8'd32) begin
      failures++;
      $display("FAIL reset_regs: cursor=(%0d,%0d) id=%0d required (0,0) id=32",
               cursor_row, cursor_col, character_id);
    end
    reset = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 512) begin
      failures++;
      $display("FAIL reset_busy_len: got %0d cycles required 512", n);
    end
    model_clear();
  endtask

  task automatic test_grid_contents(input string tag);
    int got, exp, bad;
    bad = 0;
    for (int r = 0; r < 16; r++) begin
      for (int c = 0; c < 32; c++) begin
        lookup(r, c, got, exp);
        checks++;
        if (got !== exp) begin
          failures++;
          if (bad < 8) $display("FAIL grid_%s (%0d,%0d): got %0d required %0d", tag, r, c, got, exp);
          bad++;
        end
      end
    end
  endtask

  task automatic test_backspace_basic();
    bit s;
    int got, exp;
    send_char(8'h41, s);
    send_char(8'h42, s);
    lookup(0, 0, got, exp);
    checks++;
    if (got !== 65) begin failures++; $display("FAIL bs_cell00: got %0d required 65", got); end
    lookup(0, 1, got, exp);
    checks++;
    if (got !== 66) begin failures++; $display("FAIL bs_cell01: got %0d required 66", got); end
    checks++;
    if (cursor_row !== 4'd0 || cursor_col !== 5'd2) begin
      failures++;
      $display("FAIL bs_cursor_ab: got (%0d,%0d) required (0,2)", cursor_row, cursor_col);
    end
    send_char(8'h08, s);
    lookup(0, 1, got, exp);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL bs_erase01: got %0d required %0d", got, exp); end
    checks++;
    if (cursor_row !== 4'd0 || cursor_col !== 5'd1) begin
      failures++;
      $display("FAIL bs_cursor_1: got (%0d,%0d) required (0,1)", cursor_row, cursor_col);
    end
    for (int k = 0; k < 2; k++) begin
      send_char(8'h08, s);
      checks++;
      if (cursor_row !== 4'd0 || cursor_col !== 5'd0) begin
        failures++;
        $display("FAIL bs_cursor_home%0d: got (%0d,%0d) required (0,0)", k, cursor_row, cursor_col);
      end
    end
  endtask

  task automatic test_row_wrap();
    bit s;
    int got, exp, c;
    for (int i = 0; i < 32; i++) send_char(8'($urandom_range(33, 126)), s);
    checks++;
    if (cursor_row !== 4'd1 || cursor_col !== 5'd0) begin
      failures++;
      $display("FAIL wrap_cursor: got (%0d,%0d) required (1,0)", cursor_row, cursor_col);
    end
    for (int k = 0; k < 4; k++) begin
      c = $urandom_range(0, 31);
      lookup(0, c, got, exp);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL wrap_cell(0,%0d): got %0d required %0d", c, got, exp); end
    end
    send_char(8'h08, s);
    checks++;
    if (cursor_row !== 4'd0 || cursor_col !== 5'd31) begin
      failures++;
      $display("FAIL wrap_bs_cursor: got (%0d,%0d) required (0,31)", cursor_row, cursor_col);
    end
    lookup(0, 31, got, exp);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL wrap_bs_cell: got %0d required %0d", got, exp); end
  endtask

  task automatic test_scroll_newline();
    bit s;
    int n, got, exp;
    send_char(8'h0A, s);
    send_char(8'h58, s);
    for (int i = 0; i < 14; i++) send_char(8'h0D, s);
    for (int i = 0; i < 5; i++) send_char(8'($urandom_range(33, 126)), s);
    checks++;
    if (cursor_row !== 4'd15 || cursor_col !== 5'd5) begin
      failures++;
      $display("FAIL scroll_pre_cursor: got (%0d,%0d) required (15,5)", cursor_row, cursor_col);
    end
    send_char(8'h0A, s);
    count_busy(n);
    checks++;
    if (n !== 512 || s !== 1'b1) begin
      failures++;
      $display("FAIL scroll_busy_len: got %0d cycles required 512", n);
    end
    lookup(0, 0, got, exp);
    checks++;
    if (got !== 88) begin failures++; $display("FAIL scroll_cell00: got %0d required 88", got); end
    for (int c = 1; c < 32; c++) begin
      lookup(15, c, got, exp);
      checks++;
      if (got !== 32) begin failures++; $display("FAIL scroll_row15(%0d): got %0d required 32", c, got); end
    end
    checks++;
    if (cursor_row !== 4'd15 || cursor_col !== 5'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL scroll_post: cursor=(%0d,%0d) in_ready=%0b required (15,0) ready=1",
               cursor_row, cursor_col, in_ready);
    end
  endtask

  task automatic test_clear_during_scroll();
    bit s;
    int n;
    send_char(8'h0A, s);
    repeat (99) @(negedge clk);
    clear = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clear = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 924) begin
      failures++;
      $display("FAIL scroll_then_clear_len: got %0d remaining busy cycles required 924", n);
    end
    model_clear();
    checks++;
    if (cursor_row !== 4'd0 || cursor_col !== 5'd0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL scroll_then_clear_cursor: got (%0d,%0d) ready=%0b required (0,0) ready=1",
               cursor_row, cursor_col, in_ready);
    end
  endtask

  task automatic test_clear_idle();
    bit s;
    int n, got, exp, r, c;
    for (int i = 0; i < 3; i++) send_char(8'($urandom_range(33, 126)), s);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_char  = 8'h5A;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL clear_blocks_ready: got %0b required 0", in_ready); end
    @(posedge clk);
    @(negedge clk);
    clear    = 1'b0;
    in_valid = 1'b0;
    count_busy(n);
    checks++;
    if (n !== 512) begin failures++; $display("FAIL clear_idle_len: got %0d cycles required 512", n); end
    model_clear();
    checks++;
    if (cursor_row !== 4'd0 || cursor_col !== 5'd0) begin
      failures++;
      $display("FAIL clear_idle_cursor: got (%0d,%0d) required (0,0)", cursor_row, cursor_col);
    end
    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 15);
      c = $urandom_range(0, 31);
      lookup(r, c, got, exp);
      checks++;
      if (got !== exp) begin failures++; $display("FAIL clear_idle_cell(%0d,%0d): got %0d required %0d", r, c, got, exp); end
    end
  endtask

  task automatic test_same_edge_lookup();
    bit s;
    int got, exp;
    for (int i = 0; i < 3; i++) send_char(8'h0A, s);
    for (int i = 0; i < 4; i++) send_char(8'($urandom_range(33, 126)), s);
    char_row = 4'd3;
    char_col = 5'd4;
    in_valid = 1'b1;
    in_char  = 8'h51;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    got = int'(character_id);
    exp = expect_cell(3, 4);
    checks++;
    if (got !== exp) begin failures++; $display("FAIL same_edge_old: got %0d required %0d", got, exp); end
    model_apply(8'h51, s);
    lookup(3, 4, got, exp);
    checks++;
    if (got !== 81) begin failures++; $display("FAIL same_edge_next: got %0d required 81", got); end
  endtask

  task automatic test_random_stream();
    bit s;
    int n, got, exp, r, c, sel;
    logic [7:0] others [5];
    logic [7:0] ch;
    others[0] = 8'h00; others[1] = 8'h1B; others[2] = 8'h7F; others[3] = 8'h09; others[4] = 8'hC8;
    for (int i = 0; i < 300; i++) begin
      sel = $urandom_range(0, 99);
      if (sel < 10) begin
        r = $urandom_range(0, 15);
        c = $urandom_range(0, 31);
        lookup(r, c, got, exp);
        checks++;
        if (got !== exp) begin failures++; $display("FAIL rand_lookup(%0d,%0d): got %0d required %0d", r, c, got, exp); end
      end else begin
        if (sel < 65)      ch = 8'($urandom_range(32, 126));
        else if (sel < 77) ch = ($urandom_range(0, 1) == 0) ? 8'h0A : 8'h0D;
        else if (sel < 93) ch = 8'h08;
        else               ch = others[$urandom_range(0, 4)];
        send_char(ch, s);
        checks++;
        if (cursor_row !== 4'(m_row) || cursor_col !== 5'(m_col)) begin
          failures++;
          $display("FAIL rand_cursor ch=%0h: got (%0d,%0d) required (%0d,%0d)",
                   ch, cursor_row, cursor_col, m_row, m_col);
        end
        if (s) begin
          count_busy(n);
          checks++;
          if (n !== 512) begin failures++; $display("FAIL rand_scroll_len: got %0d cycles required 512", n); end
        end
      end
    end
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_char  = 8'h00;
    clear    = 1'b0;
    char_row = 4'd0;
    char_col = 5'd0;
    m_row    = 0;
    m_col    = 0;
    @(negedge clk);
    test_reset();
    test_grid_contents("post_reset");
    test_backspace_basic();
    test_row_wrap();
    test_scroll_newline();
    test_grid_contents("after_scroll");
    test_clear_during_scroll();
    test_grid_contents("after_clear");
    test_clear_idle();
    test_same_edge_lookup();
    test_random_stream();
    test_grid_contents("after_random");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
